instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h00000000: bubble instruction inserted on flush or halt.
REQ-003 Clk  input  1  single clock, rising edge; one clock domain.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  holds the PC and the IF/ID register.
REQ-006 Flush  input  1  replaces the next IF/ID contents with a bubble.
REQ-007 Redirect  input  1  loads RedirectPC on the next edge (branch, j, jal, jr).
REQ-008 RedirectPC  input  32  redirect target byte address.
REQ-009 InstrAddr  output  32  current PC, driven combinationally to the instruction memory.
REQ-010 InstrIn  input  32  instruction word returned combinationally for InstrAddr.
REQ-011 IFID_Instruction  output  32  registered instruction.
REQ-012 IFID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-013 IFID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-014 Halted  output  1  1 while the FSM is in HALTED.

Function
REQ-015 InstrAddr SHALL equal the PC register with zero combinational delay from the register.
REQ-016 PC next-state priority SHALL be: Reset > Redirect > HALTED hold > Stall hold > PC+4.
REQ-017 On Redirect, PC SHALL load {RedirectPC[31:2], 2'b00}; bits [1:0] are always 0.
REQ-018 PC+4 SHALL wrap modulo 2^32, so 32'hFFFFFFFC goes to 32'h00000000.
REQ-019 IF/ID priority SHALL be: Reset > (Redirect or Flush) bubble > Stall hold > load {InstrIn, PC+4, 1}.
REQ-020 A bubble SHALL set IFID_Instruction=NOP_WORD, IFID_Valid=0, and IFID_PCPlus4=PC+4 of the current PC.
REQ-021 Flush with Stall SHALL produce a bubble while the PC still holds.
REQ-022 Redirect with Stall SHALL load RedirectPC and produce a bubble.
REQ-023 Fetch latency SHALL be one cycle: the instruction at PC appears in IF/ID after the next rising edge.
REQ-024 The FSM SHALL have two states, RUN and HALTED.
REQ-025 RUN to HALTED SHALL occur on an edge where:
- the state is RUN, and Stall, Flush and Redirect are all 0, and
- InstrIn[31:26]=6'b000010, and
- InstrIn[25:0]=PC[27:2] (a jump to itself).
REQ-026 On that RUN-to-HALTED edge, the jump SHALL load into IF/ID normally with Valid=1.
REQ-027 In HALTED: the PC holds, IF/ID receives bubbles every cycle, and Halted=1.
REQ-028 HALTED to RUN SHALL occur only on Redirect, which follows REQ-017 and REQ-022; Stall and Flush are ignored in HALTED.

Reset
REQ-029 On a Reset edge:
- PC=RESET_PC and FSM=RUN;
- IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0;
- Halted=0.
REQ-030 Reset asserted mid-operation SHALL override Stall, Flush, Redirect and HALTED in the same edge.
REQ-031 Reset SHALL have no effect between clock edges.

Structure
REQ-032 A shared package SHALL hold:
- the J opcode 6'b000010;
- the FSM state encoding (RUN=0, HALTED=1);
- the default NOP_WORD.
REQ-033 The IF/ID register SHALL be one sub-module, ifid_register, with inputs load, bubble and reset.
REQ-034 The PC register, next-PC mux and FSM SHALL live in instruction_fetch_stage.

Verification
REQ-035 Reset held 2 cycles, then released, with InstrIn=32'h34040000:
- during reset: InstrAddr=0, IFID_Valid=0, Halted=0;
- after the first edge: IFID_Instruction=32'h34040000, IFID_PCPlus4=4, InstrAddr=4.
REQ-036 Stall=1 for 3 cycles at PC=8: InstrAddr stays 8 and IF/ID is unchanged; after release, PC becomes 12.
REQ-037 Redirect=1 with RedirectPC=32'h00000133 at PC=0x40:
- next InstrAddr=32'h00000130;
- IFID_Valid=0, IFID_Instruction=0.
REQ-038 Self-jump halt at PC=32'h000001D0 with InstrIn=32'h08000074:
- IF/ID captures the jump with Valid=1, then Halted=1;
- InstrAddr stays 0x1D0 and Valid=0 on later cycles;
- Redirect to 0 returns to RUN with InstrAddr=0.
REQ-039 Flush and Stall together at PC=0x20: IFID_Valid=0, InstrAddr stays 0x20.
REQ-040 Wrap and mid-run reset:
- a redirect to 32'hFFFFFFFC, followed by one sequential edge, gives InstrAddr=0 and IFID_PCPlus4=0;
- Reset asserted together with Redirect gives PC=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// ============================================================================
// Module  : instruction_fetch_stage_pkg
// Purpose : Shared constants, state encoding and types for the fetch stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package instruction_fetch_stage_pkg;

    localparam logic [5:0]  c_j_opcode  = 6'b000010;
    localparam logic [0:0]  c_st_run    = 1'b0;
    localparam logic [0:0]  c_st_halted = 1'b1;
    localparam logic [31:0] c_nop_word  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    // A halt is a J whose target word address equals the word address of the PC.
    function automatic logic is_self_jump(input logic [31:0] instr,
                                          input logic [25:0] pc_word);
        return (instr[31:26] == c_j_opcode) && (instr[25:0] == pc_word);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_stage_if.sv
// ============================================================================
// Module  : instruction_fetch_stage_if
// Purpose : Control, instruction-memory and IF/ID signals of the fetch stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_stage_if;

    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_in;
    logic [31:0] instr_addr;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        halted;

    // Pipeline control and instruction memory side.
    modport master (
        output stall, flush, redirect, redirect_pc, instr_in,
        input  instr_addr, ifid_instruction, ifid_pc_plus4, ifid_valid, halted
    );

    // Fetch stage side.
    modport slave (
        input  stall, flush, redirect, redirect_pc, instr_in,
        output instr_addr, ifid_instruction, ifid_pc_plus4, ifid_valid, halted
    );

endinterface

`default_nettype wire

// File: rtl/instruction_fetch_stage_ifid.sv
// ============================================================================
// Module  : ifid_register
// Purpose : IF/ID pipeline register with reset > bubble > load > hold priority.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ifid_register
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = c_nop_word
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load,
    input  wire logic        bubble,
    input  wire logic [31:0] instr_in,
    input  wire logic [31:0] pc_plus4_in,
    output ifid_t            entry
);

    ifid_t r_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry.instruction <= NOP_WORD;
            r_entry.pc_plus4    <= 32'h0000_0000;
            r_entry.valid       <= 1'b0;
        end else if (bubble) begin
            r_entry.instruction <= NOP_WORD;
            r_entry.pc_plus4    <= pc_plus4_in;
            r_entry.valid       <= 1'b0;
        end else if (load) begin
            r_entry.instruction <= instr_in;
            r_entry.pc_plus4    <= pc_plus4_in;
            r_entry.valid       <= 1'b1;
        end
    end

    assign entry = r_entry;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module  : instruction_fetch_stage
// Purpose : PC register, next-PC selection and RUN/HALTED control for fetch.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = c_nop_word
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    instruction_fetch_stage_if.slave       bus
);

    logic [31:0] r_pc;
    logic [0:0]  r_state;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic        w_is_halted;
    logic        w_halt_detect;
    logic        w_bubble;
    ifid_t       w_ifid;

    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_redirect_target = {bus.redirect_pc[31:2], 2'b00};
    assign w_is_halted       = (r_state == c_st_halted);

    assign w_halt_detect = (r_state == c_st_run) && !bus.stall && !bus.flush
                        && !bus.redirect && is_self_jump(bus.instr_in, r_pc[27:2]);

    // The self-jump target is the current PC, so the PC also holds on the halting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (bus.redirect) begin
            r_pc <= w_redirect_target;
        end else if (w_is_halted || w_halt_detect) begin
            r_pc <= r_pc;
        end else if (bus.stall) begin
            r_pc <= r_pc;
        end else begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
        end else if (bus.redirect) begin
            r_state <= c_st_run;
        end else if (w_halt_detect) begin
            r_state <= c_st_halted;
        end
    end

    // HALTED bubbles every cycle regardless of stall or flush.
    assign w_bubble = bus.redirect || bus.flush || w_is_halted;

    ifid_register #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid (
        .clk         (clk),
        .rst         (rst),
        .load        (!bus.stall),
        .bubble      (w_bubble),
        .instr_in    (bus.instr_in),
        .pc_plus4_in (w_pc_plus4),
        .entry       (w_ifid)
    );

    assign bus.instr_addr       = r_pc;
    assign bus.ifid_instruction = w_ifid.instruction;
    assign bus.ifid_pc_plus4    = w_ifid.pc_plus4;
    assign bus.ifid_valid       = w_ifid.valid;
    assign bus.halted           = w_is_halted;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module  : tb_instruction_fetch_stage
// Purpose : Directed vector bench for instruction_fetch_stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    instruction_fetch_stage_if bus ();

    instruction_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] instr;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic d,
                                input logic [31:0] rpc, input logic [31:0] ins,
                                input logic [31:0] ea, input logic [31:0] ei,
                                input logic [31:0] ep, input logic ev, input logic eh);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.redirect = d;
        v.rpc = rpc; v.instr = ins;
        v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_halted = eh;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0; bus.instr_in = 32'h0;

        // Fields: rst stall flush redirect rpc instr | addr instr pc4 valid halted (after edge)
        vecs[0]  = mk(1,0,0,0,32'h0,  32'h34040000, 32'h0,   32'h0,        32'h0,   0,0);
        vecs[1]  = mk(1,0,0,0,32'h0,  32'h34040000, 32'h0,   32'h0,        32'h0,   0,0);
        vecs[2]  = mk(0,0,0,0,32'h0,  32'h34040000, 32'h4,   32'h34040000, 32'h4,   1,0);
        vecs[3]  = mk(0,0,0,0,32'h0,  32'h11111111, 32'h8,   32'h11111111, 32'h8,   1,0);
        vecs[4]  = mk(0,1,0,0,32'h0,  32'h22222222, 32'h8,   32'h11111111, 32'h8,   1,0);
        vecs[5]  = mk(0,1,0,0,32'h0,  32'h22222222, 32'h8,   32'h11111111, 32'h8,   1,0);
        vecs[6]  = mk(0,1,0,0,32'h0,  32'h22222222, 32'h8,   32'h11111111, 32'h8,   1,0);
        vecs[7]  = mk(0,0,0,0,32'h0,  32'h22222222, 32'hC,   32'h22222222, 32'hC,   1,0);
        vecs[8]  = mk(0,0,0,1,32'h40, 32'h33333333, 32'h40,  32'h0,        32'h10,  0,0);
        vecs[9]  = mk(0,0,0,1,32'h133,32'h33333333, 32'h130, 32'h0,        32'h44,  0,0);
        vecs[10] = mk(0,0,0,0,32'h0,  32'h44444444, 32'h134, 32'h44444444, 32'h134, 1,0);
        vecs[11] = mk(0,1,0,1,32'h20, 32'h55555555, 32'h20,  32'h0,        32'h138, 0,0);
        vecs[12] = mk(0,1,1,0,32'h0,  32'h66666666, 32'h20,  32'h0,        32'h24,  0,0);
        vecs[13] = mk(0,0,1,0,32'h0,  32'h77777777, 32'h24,  32'h0,        32'h24,  0,0);
        vecs[14] = mk(0,0,0,1,32'h1D0,32'h0,        32'h1D0, 32'h0,        32'h28,  0,0);
        vecs[15] = mk(0,0,0,0,32'h0,  32'h08000074, 32'h1D0, 32'h08000074, 32'h1D4, 1,1);
        vecs[16] = mk(0,1,1,0,32'h0,  32'h08000074, 32'h1D0, 32'h0,        32'h1D4, 0,1);
        vecs[17] = mk(0,0,0,0,32'h0,  32'h08000074, 32'h1D0, 32'h0,        32'h1D4, 0,1);
        vecs[18] = mk(0,0,0,1,32'h0,  32'h08000074, 32'h0,   32'h0,        32'h1D4, 0,0);
        vecs[19] = mk(0,0,0,0,32'h0,  32'h88888888, 32'h4,   32'h88888888, 32'h4,   1,0);
        vecs[20] = mk(0,0,0,1,32'hFFFFFFFE,32'h0,   32'hFFFFFFFC,32'h0,     32'h8,   0,0);
        vecs[21] = mk(0,0,0,0,32'h0,  32'h99999999, 32'h0,   32'h99999999, 32'h0,   1,0);
        vecs[22] = mk(0,0,0,0,32'h0,  32'hAAAAAAAA, 32'h4,   32'hAAAAAAAA, 32'h4,   1,0);
        vecs[23] = mk(1,0,0,1,32'h100,32'hAAAAAAAA, 32'h0,   32'h0,        32'h0,   0,0);
        vecs[24] = mk(0,0,0,1,32'h1D0,32'h0,        32'h1D0, 32'h0,        32'h4,   0,0);
        vecs[25] = mk(0,0,0,0,32'h0,  32'h08000075, 32'h1D4, 32'h08000075, 32'h1D4, 1,0);
        vecs[26] = mk(0,0,0,1,32'h1D0,32'h0,        32'h1D0, 32'h0,        32'h1D8, 0,0);
        vecs[27] = mk(0,0,0,0,32'h0,  32'h08000074, 32'h1D0, 32'h08000074, 32'h1D4, 1,1);
        vecs[28] = mk(1,1,1,1,32'h300,32'h08000074, 32'h0,   32'h0,        32'h0,   0,0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            bus.stall       = vecs[i].stall;
            bus.flush       = vecs[i].flush;
            bus.redirect    = vecs[i].redirect;
            bus.redirect_pc = vecs[i].rpc;
            bus.instr_in    = vecs[i].instr;
            @(posedge clk);
            #1;
            check("instr_addr",       i, bus.instr_addr,       vecs[i].e_addr);
            check("ifid_instruction", i, bus.ifid_instruction, vecs[i].e_instr);
            check("ifid_pc_plus4",    i, bus.ifid_pc_plus4,    vecs[i].e_pc4);
            check("ifid_valid",       i, {31'h0, bus.ifid_valid}, {31'h0, vecs[i].e_valid});
            check("halted",           i, {31'h0, bus.halted},     {31'h0, vecs[i].e_halted});
        end

        // A reset pulse that never spans a rising edge must leave the stage untouched.
        @(negedge clk);
        rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect = 1'b0;
        bus.instr_in = 32'hBBBBBBBB;
        @(posedge clk);
        #1;
        check("seq_addr", 100, bus.instr_addr, 32'h4);
        @(negedge clk);
        bus.stall = 1'b1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_addr",  101, bus.instr_addr,       32'h4);
        check("glitch_instr", 101, bus.ifid_instruction, 32'hBBBBBBBB);
        check("glitch_valid", 101, {31'h0, bus.ifid_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
